// File: rtl/adc_capture_axis_block_detector_pkg.sv
// Shared types and helpers for the AXI-Stream block-signal detector.
// Holds the FSM state encoding, a saturating increment, and default constants.
package adc_capture_dbg_pkg;

    // Global deadlock FSM; the encoding is exported on state_dbg.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam int DEF_NUM_CH       = 2;
    localparam int DEF_STALL_THRESH = 16;
    localparam int DEF_CONFIRM_CYC  = 32;
    localparam int DEF_CNT_W        = 16;

    // Increment v, holding at the all-ones value of a w-bit counter.
    // The 32-bit container lets any counter width up to 32 share this helper.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] lim;
        lim = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= lim) ? lim : v + 32'd1;
    endfunction

endpackage

// File: rtl/adc_capture_axis_block_detector_if.sv
// Tap/monitor bundle for the block detector.
// The detector observes tvalid/tready of each stream, returns per-channel
// block flags to the deadlock monitor and receives the monitor's verdict.
interface adc_capture_axis_block_detector_if #(
    parameter int NUM_CH = 2
);
    logic [NUM_CH-1:0] tap_tvalid;
    logic [NUM_CH-1:0] tap_tready;
    logic [NUM_CH-1:0] axis_block_sigs;
    logic              monitor_block;

    // Environment side: drives taps and monitor verdict.
    modport master (
        output tap_tvalid,
        output tap_tready,
        output monitor_block,
        input  axis_block_sigs
    );

    // Detector side.
    modport slave (
        input  tap_tvalid,
        input  tap_tready,
        input  monitor_block,
        output axis_block_sigs
    );
endinterface

// File: rtl/adc_capture_axis_block_detector_stall_counter.sv
// Per-channel stall tracker: decodes a stall from one tapped stream, counts
// consecutive stall cycles (saturating) and registers the block flag.
// Optional ADC_CAPTURE_MAX_STALL_EN adds a running maximum of the stall count.
module adc_capture_stall_counter
    import adc_capture_dbg_pkg::*;
#(
    parameter bit IS_INPUT     = 1'b1,
    parameter int STALL_THRESH = DEF_STALL_THRESH,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
`ifdef ADC_CAPTURE_MAX_STALL_EN
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_max_stall,
`endif
    input  logic             i_tvalid,
    input  logic             i_tready,
    output logic             o_block
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_block;
    logic             w_stall;
    logic [31:0]      w_inc;
    logic [31:0]      w_cnt_nxt;

    // Input channel stalls when the module waits for data; output channel
    // stalls when its data is not accepted. A transfer never matches either.
    assign w_stall = IS_INPUT ? (i_tready & ~i_tvalid) : (i_tvalid & ~i_tready);

    assign w_inc     = sat_inc(32'(r_cnt), CNT_W);
    assign w_cnt_nxt = w_stall ? w_inc : 32'd0;

    // Consecutive-stall counter and block flag derived from its next value.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_cnt   <= '0;
            r_block <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt[CNT_W-1:0];
            r_block <= (w_cnt_nxt >= 32'(STALL_THRESH));
        end
    end

    assign o_block = r_block;

`ifdef ADC_CAPTURE_MAX_STALL_EN
    logic [CNT_W-1:0] r_max;

    // Running maximum of the stall count, cleared with the sticky report.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n || i_clear) begin
            r_max <= '0;
        end else if (w_cnt_nxt > 32'(r_max)) begin
            r_max <= w_cnt_nxt[CNT_W-1:0];
        end
    end

    assign o_max_stall = r_max;
`endif

endmodule

// File: rtl/adc_capture_axis_block_detector.sv
// Producer of the per-stream block-signal vector for the HLS deadlock monitor.
// Each channel gets a stall counter; a global FSM confirms a deadlock when the
// monitor's verdict persists and latches a sticky mask/cycle report.
// Optional macro ADC_CAPTURE_MAX_STALL_EN adds the o_max_stall output.
module adc_capture_axis_block_detector
    import adc_capture_dbg_pkg::*;
#(
    parameter int                NUM_CH       = DEF_NUM_CH,
    parameter logic [NUM_CH-1:0] CH_IS_INPUT  = 2'b01,
    parameter int                STALL_THRESH = DEF_STALL_THRESH,
    parameter int                CONFIRM_CYC  = DEF_CONFIRM_CYC,
    parameter int                CNT_W        = DEF_CNT_W
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    input  logic                     i_clear,
    adc_capture_axis_block_detector_if.slave bus,
    output logic                     o_deadlock,
    output logic [NUM_CH-1:0]        o_deadlock_mask,
    output logic [CNT_W-1:0]         o_deadlock_cycles,
`ifdef ADC_CAPTURE_MAX_STALL_EN
    output logic [NUM_CH*CNT_W-1:0]  o_max_stall,
`endif
    output logic [1:0]               o_state_dbg
);

    logic [NUM_CH-1:0] w_block;

`ifdef ADC_CAPTURE_MAX_STALL_EN
    logic [NUM_CH-1:0][CNT_W-1:0] w_max;
    assign o_max_stall = w_max;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        adc_capture_stall_counter #(
            .IS_INPUT     (CH_IS_INPUT[g]),
            .STALL_THRESH (STALL_THRESH),
            .CNT_W        (CNT_W)
        ) u_stall (
            .i_clock     (i_clock),
            .i_reset_n   (i_reset_n),
`ifdef ADC_CAPTURE_MAX_STALL_EN
            .i_clear     (i_clear),
            .o_max_stall (w_max[g]),
`endif
            .i_tvalid    (bus.tap_tvalid[g]),
            .i_tready    (bus.tap_tready[g]),
            .o_block     (w_block[g])
        );
    end

    assign bus.axis_block_sigs = w_block;

    state_t            r_state;
    logic [CNT_W-1:0]  r_confirm;
    logic              r_deadlock;
    logic [NUM_CH-1:0] r_mask;
    logic [CNT_W-1:0]  r_cycles;
    logic [31:0]       w_confirm_inc;

    // RUN holds confirm_cnt at 0, so one increment path serves both the
    // RUN->SUSPECT load of 1 and the SUSPECT count-up.
    assign w_confirm_inc = sat_inc(32'(r_confirm), CNT_W);

    // Deadlock confirmation FSM with sticky report; clear beats every transition.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n || i_clear) begin
            r_state    <= ST_RUN;
            r_confirm  <= '0;
            r_deadlock <= 1'b0;
            r_mask     <= '0;
            r_cycles   <= '0;
        end else begin
            case (r_state)
                ST_RUN, ST_SUSPECT: begin
                    if (bus.monitor_block) begin
                        r_confirm <= w_confirm_inc[CNT_W-1:0];
                        if (w_confirm_inc >= 32'(CONFIRM_CYC)) begin
                            r_state    <= ST_LOCKED;
                            r_deadlock <= 1'b1;
                            r_mask     <= w_block;
                            r_cycles   <= w_confirm_inc[CNT_W-1:0];
                        end else begin
                            r_state <= ST_SUSPECT;
                        end
                    end else begin
                        r_state   <= ST_RUN;
                        r_confirm <= '0;
                    end
                end
                ST_LOCKED: begin
                    r_state <= ST_LOCKED;
                end
                default: begin
                    r_state   <= ST_RUN;
                    r_confirm <= '0;
                end
            endcase
        end
    end

    assign o_deadlock        = r_deadlock;
    assign o_deadlock_mask   = r_mask;
    assign o_deadlock_cycles = r_cycles;
    assign o_state_dbg       = r_state;

endmodule
